alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  1  0 = unsigned MUL 16x16->32, 1 = unsigned DIV 16/16.
REQ-006 opa  input  16  multiplicand or dividend, captured when start is accepted.
REQ-007 opb  input  16  multiplier or divisor, captured when start is accepted.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse; results valid.
REQ-010 result_hi  output  16  MUL: product[31:16]; DIV: remainder.
REQ-011 result_lo  output  16  MUL: product[15:0]; DIV: quotient.
REQ-012 div_by_zero  output  1  set with done when DIV has opb==0; held until the next accept.
REQ-013 alu_a, alu_b  output  16 each  operands driven to the shared 16-bit ALU.
REQ-014 alu_code  output  3  ALU op select: 000 ADD, 001 SUB, 011 set-less-than.
REQ-015 alu_out  input  16  ALU result.
REQ-016 alu_carry  input  1  ALU carry-out; meaningful for ADD only.

Function
REQ-017 States SHALL be IDLE, MUL_STEP, DIV_CMP, DIV_SUB and DONE, with a 4-bit step counter.
REQ-018 IDLE + start SHALL capture opa/opb, clear div_by_zero and the counter, and enter MUL_STEP (op=0), DIV_CMP (op=1, opb!=0) or DONE (op=1, opb==0).
REQ-019 A start seen in any state other than IDLE SHALL be ignored, with no effect on state or registers.
REQ-020 busy SHALL be 1 exactly in MUL_STEP, DIV_CMP and DIV_SUB.
REQ-021 done SHALL be 1 exactly in DONE; DONE SHALL return to IDLE on the next cycle.
REQ-022 result_hi, result_lo and div_by_zero SHALL hold their values through IDLE until the next accept.
REQ-023 In IDLE and DONE the ALU drive SHALL be alu_a=0, alu_b=0, alu_code=000.
REQ-024 MUL loads hi=0, lo=opb, mcand=opa; each MUL_STEP drives alu_a=hi, alu_b=mcand, alu_code=000.
REQ-025 In each MUL_STEP, s17 SHALL be {alu_carry,alu_out} if lo[0]=1, else {0,hi}; then hi<=s17[16:1] and lo<={s17[0],lo[15:1]}.
REQ-026 MUL SHALL run 16 MUL_STEP cycles (counter 0..15), then enter DONE; accept at cycle T gives done at T+17.
REQ-027 DIV loads rem=0, quo=opa, dvsr=opb.
REQ-028 In DIV_CMP: sh={rem[14:0],quo[15]}; drive alu_a=sh, alu_b=dvsr, alu_code=011; then rem<=sh, quo<={quo[14:0],0}, ge<=~alu_out[0].
REQ-029 In DIV_SUB: drive alu_a=rem, alu_b=dvsr, alu_code=001; if ge, rem<=alu_out and quo[0]<=1.
REQ-030 A 17-bit partial remainder cannot occur: the remainder after k steps is below 2^k.
REQ-031 DIV SHALL run 16 DIV_CMP/DIV_SUB pairs, with the counter advancing in DIV_SUB, then enter DONE; done at T+33.
REQ-032 DIV by zero SHALL produce done at T+1 with result_lo=0xFFFF, result_hi=opa, div_by_zero=1.
REQ-033 Outputs in DONE: MUL gives result_hi=hi, result_lo=lo; DIV gives result_hi=rem, result_lo=quo.

Reset
REQ-034 reset SHALL take priority over start and over every state, including mid-operation.
REQ-035 On reset the block SHALL enter IDLE on the next edge.
REQ-036 On reset all outputs SHALL go to 0, and all internal registers and the counter SHALL clear.

Verification
REQ-037 MUL opa=0x0003, opb=0x0005 -> done at T+17, hi=0x0000, lo=0x000F, busy high T+1..T+16.
REQ-038 MUL 0xFFFF x 0xFFFF -> hi=0xFFFE, lo=0x0001; checks the carry path in every step.
REQ-039 DIV 100/7 -> done at T+33, lo=14, hi=2; DIV 0xFFFF/0x8001 -> lo=0x0001, hi=0x7FFE.
REQ-040 DIV 0x1234/0x0000 -> done at T+1, lo=0xFFFF, hi=0x1234, div_by_zero=1, alu_code stays 000.
REQ-041 reset at T+8 of a MUL -> IDLE next cycle, busy=0, done=0, results=0; a fresh MUL 2x2 then gives lo=4 at +17.
REQ-042 start pulsed during busy and during DONE -> ignored; in-flight result unchanged; next op accepted only from IDLE.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle unsigned 16x16->32 multiply and 16/16 divide, sequenced over
//   an external shared 16-bit ALU. Multiply is shift-and-add (16 steps).
//   Divide is restoring: a compare step followed by a conditional subtract
//   step for each of 16 quotient bits. Divide by zero finishes on the cycle
//   after the start is accepted.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   start, op, opa, opb   request (op 0 = MUL, 1 = DIV), captured in IDLE only
//   busy, done            busy while stepping; done is a one-cycle pulse
//   result_hi, result_lo  MUL: product[31:16]/[15:0]; DIV: remainder/quotient
//   div_by_zero           flags a DIV with opb == 0; held until the next accept
//   alu_a, alu_b,
//   alu_code              operand/op-select drive to the shared ALU
//   alu_out, alu_carry    ALU result and ADD carry-out
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic        busy,
  output logic        done,
  output logic [15:0] result_hi,
  output logic [15:0] result_lo,
  output logic        div_by_zero,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_code,
  input  logic [15:0] alu_out,
  input  logic        alu_carry
);

  localparam int DATA_W = 16;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] MUL_STEP = 3'd1;
  localparam logic [2:0] DIV_CMP  = 3'd2;
  localparam logic [2:0] DIV_SUB  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b011;

  logic [2:0]        state;
  logic [3:0]        step_cnt;
  // hi holds the product high half (MUL) or the partial remainder (DIV);
  // lo holds the multiplier/product low half (MUL) or dividend/quotient (DIV).
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] opnd;     // multiplicand (MUL) or divisor (DIV)
  logic              ge;       // shifted remainder >= divisor, from DIV_CMP
  logic              dbz;

  logic [DATA_W-1:0] sh;
  logic [DATA_W:0]   s17;

  // Remainder shifted left by one with the next dividend bit brought in.
  assign sh  = {hi[DATA_W-2:0], lo[DATA_W-1]};
  // Add the multiplicand only when the current multiplier bit is set.
  assign s17 = lo[0] ? {alu_carry, alu_out} : {1'b0, hi};

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_code = ALU_ADD;
    case (state)
      MUL_STEP: begin
        alu_a    = hi;
        alu_b    = opnd;
        alu_code = ALU_ADD;
      end
      DIV_CMP: begin
        alu_a    = sh;
        alu_b    = opnd;
        alu_code = ALU_SLT;
      end
      DIV_SUB: begin
        alu_a    = hi;
        alu_b    = opnd;
        alu_code = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step_cnt <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      ge       <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            step_cnt <= '0;
            dbz      <= 1'b0;
            ge       <= 1'b0;
            if (!op) begin
              hi    <= '0;
              lo    <= opb;
              opnd  <= opa;
              state <= MUL_STEP;
            end else if (opb != '0) begin
              hi    <= '0;
              lo    <= opa;
              opnd  <= opb;
              state <= DIV_CMP;
            end else begin
              hi    <= opa;
              lo    <= '1;
              opnd  <= opb;
              dbz   <= 1'b1;
              state <= DONE;
            end
          end
        end
        MUL_STEP: begin
          hi       <= s17[DATA_W:1];
          lo       <= {s17[0], lo[DATA_W-1:1]};
          step_cnt <= step_cnt + 4'd1;
          if (step_cnt == 4'd15) state <= DONE;
        end
        DIV_CMP: begin
          hi    <= sh;
          lo    <= {lo[DATA_W-2:0], 1'b0};
          ge    <= ~alu_out[0];
          state <= DIV_SUB;
        end
        DIV_SUB: begin
          if (ge) begin
            hi    <= alu_out;
            lo[0] <= 1'b1;
          end
          step_cnt <= step_cnt + 4'd1;
          state    <= (step_cnt == 4'd15) ? DONE : DIV_CMP;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state == MUL_STEP) || (state == DIV_CMP) || (state == DIV_SUB);
  assign done        = (state == DONE);
  assign result_hi   = hi;
  assign result_lo   = lo;
  assign div_by_zero = dbz;

endmodule
